// File: rtl/tx_word_feeder.sv
// tx_word_feeder: buffers 32-bit words from a valid/ready source and presents
// them one at a time to the TX serializer chain. Each word is launched with a
// one-cycle Cin strobe and then held on Din for WORD_CYCLES cycles.
// A word seen while idle is staged on one edge and launched on the next. A
// word waiting when the current hold expires is launched immediately, so
// back-to-back words keep a fixed cadence of WORD_CYCLES.
// Optional feature: define TXF_IDLE_FILL_EN to emit IDLE_WORD whenever the
// FIFO is starved. Cin then never stops after reset.
`timescale 1ns/1ps

module tx_word_feeder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WORD_CYCLES = 4,
    parameter logic [31:0] IDLE_WORD   = 32'hBCBC_BCBC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     flush,
    output logic                     Cin,
    output logic [31:0]              Din,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(WORD_CYCLES);

    localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

`ifdef TXF_IDLE_FILL_EN
    localparam bit IDLE_FILL = 1'b1;
`else
    localparam bit IDLE_FILL = 1'b0;
`endif

    logic [31:0]      mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [31:0]      head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             hold_done;

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             launch_q;   // a staged word waits to be launched from IDLE
    logic [31:0]      stage_q;

    // FIFO status and handshake; the extra pointer bit separates full from empty
    assign fill      = wr_ptr - rd_ptr;
    assign full      = (fill == FULL_LVL);
    assign empty     = (fill == '0);
    assign s_ready   = !full;
    assign head      = mem[rd_ptr[ADDR_W-1:0]];
    assign push      = s_valid && s_ready && !flush;
    assign hold_done = (state_q == ST_HOLD) && (cnt_q == '0);
    assign pop       = !flush && !empty &&
                       (((state_q == ST_IDLE) && !launch_q) || hold_done);

    // FIFO storage write
    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= s_data;
        end
    end

    // FIFO pointers; flush empties the FIFO and wins over a simultaneous push
    // NOTE: every register here uses <= so all state updates see the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Launch/hold sequencer driving the registered Cin, Din and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            stage_q  <= '0;
            Cin      <= 1'b0;
            Din      <= '0;
            busy     <= 1'b0;
        end else if (flush) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            stage_q  <= '0;
            Cin      <= 1'b0;
            Din      <= '0;
            busy     <= 1'b0;
        end else begin
            Cin <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch_q) begin
                        Din      <= stage_q;
                        Cin      <= 1'b1;
                        busy     <= 1'b1;
                        cnt_q    <= CNT_LOAD;
                        launch_q <= 1'b0;
                        state_q  <= ST_HOLD;
                    end else if (!empty) begin
                        stage_q  <= head;
                        launch_q <= 1'b1;
                    end else if (IDLE_FILL) begin
                        stage_q  <= IDLE_WORD;
                        launch_q <= 1'b1;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!empty) begin
                        Din   <= head;
                        Cin   <= 1'b1;
                        cnt_q <= CNT_LOAD;
                    end else if (IDLE_FILL) begin
                        Din   <= IDLE_WORD;
                        Cin   <= 1'b1;
                        cnt_q <= CNT_LOAD;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_word_feeder.sv
// Testbench for tx_word_feeder. Stimulus drives random and directed traffic
// and pushes each accepted word with its expected launch edge into a queue.
// A separate monitor compares Cin/Din against that queue every cycle.
// Expected launch edges come from the cadence rules: a word reaching an idle
// feeder launches two edges after its push, and a word waiting when the
// previous hold ends launches WORD_CYCLES after the previous launch.
// Build with TXF_IDLE_FILL_EN defined to exercise the idle-fill variant.
`timescale 1ns/1ps

module tb_tx_word_feeder;

    localparam int DEPTH = 8;
    localparam int WC    = 4;
`ifdef TXF_IDLE_FILL_EN
    localparam logic [31:0] IDLE_WORD = 32'hBCBC_BCBC;
`endif

    typedef struct {
        logic [31:0] w;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        flush = 1'b0;
    logic        cin;
    logic [31:0] din;
    logic        busy;
    logic [3:0]  fill;

    int   cyc = 0;          // number of rising edges seen
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];         // expected launches, in order
    int   pop_q[$];         // edges at which model words leave the FIFO
    int   m_fill = 0;
    int   last_cin = -1000;
    int   g0 = 0;           // second edge after reset release

    tx_word_feeder #(.DEPTH(DEPTH), .WORD_CYCLES(WC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .flush   (flush),
        .Cin     (cin),
        .Din     (din),
        .busy    (busy),
        .fill    (fill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Launch edge (return) and FIFO departure edge for a word pushed at edge e
    function automatic int next_cin(input int e, output int pop_t);
        int t;
`ifdef TXF_IDLE_FILL_EN
        t = (e + 1 > last_cin + WC) ? e + 1 : last_cin + WC;
        while (((t - g0) % WC) != 0) t++;
        pop_t = t;
`else
        if (e <= last_cin + WC - 1) begin
            t     = last_cin + WC;
            pop_t = t;
        end else begin
            t     = e + 2;
            pop_t = e + 1;
        end
`endif
        return t;
    endfunction

    // One clock of stimulus; returns just after the following falling edge
    task automatic drive_cycle(input bit want, input logic [31:0] word, output bit accepted);
        int  e;
        int  cin_t;
        int  pop_t;
        bit  exp_ready;
        e         = cyc + 1;
        exp_ready = (m_fill < DEPTH);
        check("s_ready", s_ready, exp_ready);
        s_valid  = want;
        s_data   = word;
        accepted = want && exp_ready;
        if (accepted) begin
            cin_t = next_cin(e, pop_t);
            exp_q.push_back('{word, cin_t});
            pop_q.push_back(pop_t);
            last_cin = cin_t;
            m_fill++;
        end
        @(negedge clk);
        #1;
        s_valid = 1'b0;
        while (pop_q.size() > 0 && pop_q[0] == e) begin
            void'(pop_q.pop_front());
            m_fill--;
        end
        check("fill", fill, m_fill);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive_cycle(1'b0, 32'h0, acc);
    endtask

    task automatic push_word(input logic [31:0] word);
        bit acc;
        int budget;
        acc = 1'b0;
        budget = 100;
        while (!acc && budget > 0) begin
            drive_cycle(1'b1, word, acc);
            budget--;
        end
        check("push_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (exp_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(WC + 3);
    endtask

    task automatic do_flush(input bit with_push);
        flush   = 1'b1;
        s_valid = with_push;
        s_data  = $urandom;
        exp_q.delete();
        pop_q.delete();
        m_fill   = 0;
        last_cin = -1000;
        @(negedge clk);
        #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_fill", fill, 0);
        check("flush_cin", cin, 0);
        check("flush_din", din, 0);
        check("flush_busy", busy, 0);
        check("flush_s_ready", s_ready, 1);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        flush   = 1'b0;
        exp_q.delete();
        pop_q.delete();
        m_fill   = 0;
        last_cin = -1000;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        g0    = cyc + 2;
`ifdef TXF_IDLE_FILL_EN
        last_cin = g0 - WC;
`endif
    endtask

    task automatic random_phase(input int n, input int push_pct, input int flush_pct);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (flush_pct > 0 && $urandom_range(0, 99) < flush_pct) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                drive_cycle($urandom_range(0, 99) < push_pct, $urandom, acc);
            end
        end
    endtask

    // Monitor: compares every cycle's Cin/Din with the scoreboard
    always @(negedge clk) begin
        exp_t it;
        bit   exp_cin;
        bit   slot;
        if (rst_n) begin
            exp_cin = (exp_q.size() > 0) && (exp_q[0].t == cyc);
            slot    = 1'b0;
`ifdef TXF_IDLE_FILL_EN
            slot = (cyc >= g0) && (((cyc - g0) % WC) == 0);
`endif
            check("cin", cin, exp_cin || slot);
            if (exp_cin) begin
                it = exp_q.pop_front();
                if (cin) check("din_word", din, it.w);
            end
`ifdef TXF_IDLE_FILL_EN
            else if (slot && cin) begin
                check("din_idle", din, IDLE_WORD);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int cin3;
        int cin_r;
        bit acc;
        apply_reset();

`ifndef TXF_IDLE_FILL_EN
        // Quiet link after reset
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check("rst_busy", busy, 0);
            check("rst_din", din, 0);
        end

        // Single word: launch two edges after push, held for WC cycles
        push_word(32'hDEAD_BEEF);
        idle(2);
        for (int k = 0; k < WC; k++) begin
            check("hold_busy", busy, 1);
            check("hold_din", din, 32'hDEAD_BEEF);
            idle(1);
        end
        check("end_busy", busy, 0);
        check("end_din_kept", din, 32'hDEAD_BEEF);
        idle(3);

        // Back-to-back burst through a full FIFO
        for (int i = 1; i <= 12; i++) push_word(32'(i));
        drain();

        // Flush in the middle of word 3's hold
        cin3 = 0;
        for (int i = 1; i <= 10; i++) begin
            push_word(32'(i));
            if (i == 3) cin3 = last_cin;
        end
        while (cyc < cin3 + 1) idle(1);
        do_flush(1'b1);
        push_word(32'h55);
        drain();

        // Asynchronous reset while a word is held
        push_word(32'h0BAD_F00D);
        cin_r = last_cin;
        while (cyc < cin_r) idle(1);
        rst_n = 1'b0;
        #1;
        check("arst_cin", cin, 0);
        check("arst_din", din, 0);
        check("arst_busy", busy, 0);
        check("arst_fill", fill, 0);
        check("arst_s_ready", s_ready, 1);
        apply_reset();
        push_word(32'h7777_0001);
        drain();

        // Randomized traffic with occasional flushes
        random_phase(300, 45, 1);
        drain();
        random_phase(150, 90, 0);
        drain();
`else
        // Idle fill: steady cadence with real words slotted in order
        idle(10);
        push_word(32'hA5A5_A5A5);
        drain();
        random_phase(200, 40, 0);
        drain();
        drive_cycle(1'b0, 32'h0, acc);
        idle(12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
